// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the iterative divider: it latches the operands, holds start
// until the result returns, stalls EX while waiting, and writes {rem, quot} into HI/LO.
module div_issue_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_div_valid_i,
  input  logic                ex_signed_i,
  input  logic [DATA_W-1:0]   ex_operand_1_i,
  input  logic [DATA_W-1:0]   ex_operand_2_i,
  input  logic                flush_i,
  output logic                div_start_o,
  output logic                div_signed_o,
  output logic [DATA_W-1:0]   div_operand_1_o,
  output logic [DATA_W-1:0]   div_operand_2_o,
  output logic                div_discard_o,
  input  logic [2*DATA_W-1:0] div_result_i,
  input  logic                div_ready_i,
  output logic                stall_req_o,
  output logic                hilo_we_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic                div_start_q, div_start_d;
  logic                div_signed_q, div_signed_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic                hilo_we_q, hilo_we_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                accept;
  logic                in_wait;

  assign accept  = (state_q == IDLE) & ex_div_valid_i & ~flush_i;
  assign in_wait = (state_q == WAIT);

  always_comb begin
    state_d      = state_q;
    div_start_d  = div_start_q;
    div_signed_d = div_signed_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    hilo_we_d    = 1'b0;
    hi_d         = hi_q;
    lo_d         = lo_q;
    case (state_q)
      IDLE: begin
        // div_ready_i is deliberately ignored here; the divider may still be
        // dropping its ready level after the previous start fell.
        if (accept) begin
          state_d      = WAIT;
          div_start_d  = 1'b1;
          div_signed_d = ex_signed_i;
          op1_d        = ex_operand_1_i;
          op2_d        = ex_operand_2_i;
        end
      end
      WAIT: begin
        // Flush wins over a coincident ready: the result is dropped.
        if (flush_i) begin
          state_d     = IDLE;
          div_start_d = 1'b0;
        end else if (div_ready_i) begin
          state_d     = DONE;
          div_start_d = 1'b0;
          hilo_we_d   = 1'b1;
          hi_d        = div_result_i[2*DATA_W-1:DATA_W];
          lo_d        = div_result_i[DATA_W-1:0];
        end
      end
      DONE: begin
        // The instruction retires at the end of this cycle, so a still-high
        // ex_div_valid_i belongs to it and must not reissue.
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        div_start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      div_start_q  <= 1'b0;
      div_signed_q <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      hilo_we_q    <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      div_start_q  <= div_start_d;
      div_signed_q <= div_signed_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      hilo_we_q    <= hilo_we_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign div_start_o     = div_start_q;
  assign div_signed_o    = div_signed_q;
  assign div_operand_1_o = op1_q;
  assign div_operand_2_o = op2_q;
  assign hilo_we_o       = hilo_we_q;
  assign hi_o            = hi_q;
  assign lo_o            = lo_q;
  // Discard in the first WAIT cycle overlaps start=1 so the divider never begins.
  assign div_discard_o   = flush_i & in_wait;
  assign stall_req_o     = accept | in_wait;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: the bench emulates the divider and checks each transaction
// against arithmetic expectations for directed cases and random divides, flushes and latencies.
module tb_div_issue_ctrl;
  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                ex_div_valid_i = 1'b0;
  logic                ex_signed_i = 1'b0;
  logic [DATA_W-1:0]   ex_operand_1_i = '0;
  logic [DATA_W-1:0]   ex_operand_2_i = '0;
  logic                flush_i = 1'b0;
  logic                div_start_o, div_signed_o, div_discard_o;
  logic [DATA_W-1:0]   div_operand_1_o, div_operand_2_o;
  logic [2*DATA_W-1:0] div_result_i = '0;
  logic                div_ready_i = 1'b0;
  logic                stall_req_o, hilo_we_o;
  logic [DATA_W-1:0]   hi_o, lo_o;

  int n_vec = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_hi = '0;
  logic [DATA_W-1:0] exp_lo = '0;

  div_issue_ctrl #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ex_div_valid_i(ex_div_valid_i), .ex_signed_i(ex_signed_i),
    .ex_operand_1_i(ex_operand_1_i), .ex_operand_2_i(ex_operand_2_i),
    .flush_i(flush_i),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .div_operand_1_o(div_operand_1_o), .div_operand_2_o(div_operand_2_o),
    .div_discard_o(div_discard_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .stall_req_o(stall_req_o), .hilo_we_o(hilo_we_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference divide: MIPS semantics (truncate toward zero), zero divisor -> zeros.
  task automatic ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = '0;
      r = '0;
    end else if (sgn) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Full transaction from an IDLE DUT. fl_at<0: no flush; else flush in WAIT cycle fl_at.
  // The divider answers in WAIT cycle lat (0-based).
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int fl_at);
    logic [31:0] q, r;
    bit flushed;
    ref_div(sgn, a, b, q, r);
    flushed = 1'b0;
    ex_div_valid_i = 1'b1;
    ex_signed_i    = sgn;
    ex_operand_1_i = a;
    ex_operand_2_i = b;
    flush_i        = 1'b0;
    div_ready_i    = 1'b0;
    @(negedge clk);
    chk("accept_stall", 64'(stall_req_o), 64'(1'b1));
    chk("accept_start", 64'(div_start_o), 64'(1'b0));
    step();
    ex_operand_1_i = $urandom;  // latched copy must not follow EX
    ex_operand_2_i = $urandom;
    ex_signed_i    = ~sgn;
    for (int i = 0; i <= lat; i++) begin
      div_ready_i  = (i == lat);
      div_result_i = div_ready_i ? {r, q} : {$urandom, $urandom};
      flush_i      = (i == fl_at);
      @(negedge clk);
      chk("wait_start",  64'(div_start_o),     64'(1'b1));
      chk("wait_signed", 64'(div_signed_o),    64'(sgn));
      chk("wait_op1",    64'(div_operand_1_o), 64'(a));
      chk("wait_op2",    64'(div_operand_2_o), 64'(b));
      chk("wait_stall",  64'(stall_req_o),     64'(1'b1));
      chk("wait_disc",   64'(div_discard_o),   64'(flush_i));
      chk("wait_we",     64'(hilo_we_o),       64'(1'b0));
      step();
      if (flush_i) begin
        flushed = 1'b1;
        break;
      end
    end
    if (flushed) begin
      flush_i = 1'b0;
      div_ready_i = 1'b0;
      ex_div_valid_i = 1'b0;
      @(negedge clk);
      chk("flush_start", 64'(div_start_o), 64'(1'b0));
      chk("flush_we",    64'(hilo_we_o),   64'(1'b0));
      chk("flush_stall", 64'(stall_req_o), 64'(1'b0));
      chk("flush_hi",    64'(hi_o), 64'(exp_hi));
      chk("flush_lo",    64'(lo_o), 64'(exp_lo));
      step();
      chk("flush_we2",   64'(hilo_we_o),   64'(1'b0));
      return;
    end
    // DONE cycle: EX still presents the instruction; it must not reissue.
    div_ready_i = 1'b0;
    exp_hi = r;
    exp_lo = q;
    @(negedge clk);
    chk("done_we",    64'(hilo_we_o),   64'(1'b1));
    chk("done_stall", 64'(stall_req_o), 64'(1'b0));
    chk("done_start", 64'(div_start_o), 64'(1'b0));
    chk("done_hi",    64'(hi_o), 64'(exp_hi));
    chk("done_lo",    64'(lo_o), 64'(exp_lo));
    step();
    ex_div_valid_i = 1'b0;
    @(negedge clk);
    chk("post_we",    64'(hilo_we_o),   64'(1'b0));
    chk("post_start", 64'(div_start_o), 64'(1'b0));
    chk("post_hi",    64'(hi_o), 64'(exp_hi));
    chk("post_lo",    64'(lo_o), 64'(exp_lo));
    step();
  endtask

  initial begin
    #12;
    chk("rst_start", 64'(div_start_o), 64'(1'b0));
    chk("rst_we",    64'(hilo_we_o),   64'(1'b0));
    chk("rst_hilo",  {hi_o, lo_o}, 64'(0));
    rst = 1'b1;
    step();

    run_div(1'b0, 32'd100, 32'd7, 34, -1);
    chk("divu_100_7", {hi_o, lo_o}, {32'd2, 32'd14});
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 34, -1);
    chk("div_m7_2", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div(1'b0, 32'd5, 32'd0, 3, -1);
    chk("divu_5_0", {hi_o, lo_o}, 64'(0));
    run_div(1'b0, 32'd55, 32'd4, 34, -1);
    run_div(1'b0, 32'd50, 32'd5, 34, 10);
    chk("flush10_keep", {hi_o, lo_o}, {32'd3, 32'd13});
    run_div(1'b0, 32'd9, 32'd3, 34, -1);
    chk("divu_9_3", {hi_o, lo_o}, {32'd0, 32'd3});
    run_div(1'b0, 32'd77, 32'd5, 20, 20);   // flush coincides with ready
    run_div(1'b1, 32'd77, 32'd5, 5, 0);     // flush in first WAIT cycle

    // Flush in the accept cycle: nothing issues.
    ex_div_valid_i = 1'b1; flush_i = 1'b1; ex_operand_1_i = 32'd8; ex_operand_2_i = 32'd2;
    @(negedge clk);
    chk("accflush_stall", 64'(stall_req_o), 64'(1'b0));
    chk("accflush_disc",  64'(div_discard_o), 64'(1'b0));
    step();
    ex_div_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("accflush_start", 64'(div_start_o), 64'(1'b0));
    chk("accflush_stall2", 64'(stall_req_o), 64'(1'b0));
    step();

    run_div(1'b0, 32'd20, 32'd6, 34, -1);
    chk("b2b_first", {hi_o, lo_o}, {32'd2, 32'd3});
    run_div(1'b0, 32'd21, 32'd4, 34, -1);
    chk("b2b_second", {hi_o, lo_o}, {32'd1, 32'd5});

    // Async reset mid-WAIT.
    ex_div_valid_i = 1'b1; ex_signed_i = 1'b1;
    ex_operand_1_i = 32'd123; ex_operand_2_i = 32'd7;
    step();
    ex_div_valid_i = 1'b0;
    step(); step();
    #2 rst = 1'b0;
    #1;
    chk("arst_start",  64'(div_start_o),  64'(1'b0));
    chk("arst_signed", 64'(div_signed_o), 64'(1'b0));
    chk("arst_ops",    {div_operand_1_o, div_operand_2_o}, 64'(0));
    chk("arst_hilo",   {hi_o, lo_o}, 64'(0));
    chk("arst_stall",  64'(stall_req_o), 64'(1'b0));
    chk("arst_we",     64'(hilo_we_o), 64'(1'b0));
    exp_hi = '0; exp_lo = '0;
    step();
    rst = 1'b1;
    step();

    for (int t = 0; t < 60; t++) begin
      bit sgn;
      logic [31:0] a, b;
      int lat, fl;
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      lat = (b == 0) ? $urandom_range(0, 3) : $urandom_range(0, 40);
      fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : -1;
      // Idle noise: a stray ready level must not start anything.
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        div_ready_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("idle_start", 64'(div_start_o), 64'(1'b0));
        chk("idle_stall", 64'(stall_req_o), 64'(1'b0));
        step();
        chk("idle_we", 64'(hilo_we_o), 64'(1'b0));
      end
      div_ready_i = 1'b0;
      run_div(sgn, a, b, lat, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
EX-stage controller in front of the iterative divider. It accepts a DIV/DIVU instruction from EX and latches its operands. It drives the divider's start/signed/discard inputs and stalls the pipeline until the result returns. It then writes the {remainder, quotient} result into the HI/LO registers with a one-cycle write strobe.

Parameters:
DATA_W, 32, operand width; result bus is 2*DATA_W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
ex_div_valid_i  in  1  EX holds a DIV/DIVU instruction
ex_signed_i  in  1  1=DIV (signed), 0=DIVU
ex_operand_1_i  in  DATA_W  dividend
ex_operand_2_i  in  DATA_W  divisor
flush_i  in  1  exception/pipeline flush; kills the in-flight divide
div_start_o  out  1  divider start request
div_signed_o  out  1  divider signed select
div_operand_1_o  out  DATA_W  latched dividend
div_operand_2_o  out  DATA_W  latched divisor
div_discard_o  out  1  divider discard
div_result_i  in  2*DATA_W  {remainder[63:32], quotient[31:0]}
div_ready_i  in  1  divider result valid (level, held until start drops)
stall_req_o  out  1  pipeline stall request
hilo_we_o  out  1  HI/LO write strobe
hi_o  out  DATA_W  HI register (remainder)
lo_o  out  DATA_W  LO register (quotient)

Behaviour:
- Reset (rst=0, async): state=IDLE. div_start_o, div_signed_o, hilo_we_o = 0. Operand registers, hi_o and lo_o = 0.
- States: IDLE, WAIT, DONE.
- IDLE:
  - ex_div_valid_i=1 and flush_i=0: latch operands and ex_signed_i into the div_* registers; set div_start_o=1 at the edge; go to WAIT.
  - Otherwise stay in IDLE. div_ready_i is ignored in IDLE.
- WAIT:
  - div_start_o and the div_* outputs are held stable.
  - flush_i=1: go to IDLE, div_start_o=0 at the edge, no HI/LO write. Flush has priority over a simultaneous div_ready_i.
  - flush_i=0 and div_ready_i=1: capture hi_o<=div_result_i[63:32] and lo_o<=div_result_i[31:0]; set div_start_o=0 and hilo_we_o=1 at the edge; go to DONE.
- DONE: hilo_we_o=1 for exactly this cycle; cleared at the next edge; go to IDLE. ex_div_valid_i is ignored in DONE, so the same instruction is never reissued.
- stall_req_o (combinational) = (IDLE & ex_div_valid_i & ~flush_i) | WAIT. It is 0 in DONE, so the instruction retires at the end of DONE.
- div_discard_o (combinational) = flush_i & (state==WAIT).
  - If the flush lands in the first WAIT cycle, the divider sees start=1 and discard=1 together and must not begin.
- div_start_o low in DONE/IDLE returns the divider to its ready state before any next issue.
  - Back-to-back divides: minimum 2 idle-of-start cycles (DONE, then IDLE accept).
- Latency: accept edge → WAIT; the divider takes a variable number of cycles (about 34 for normal operands, fewer for divide-by-zero); the block waits on div_ready_i with no timeout.
- Divide-by-zero: no special case. Whatever the divider returns (zeros) is written; HI=LO=0.
- hi_o/lo_o hold their value between writes. Only the DONE transition updates them.
- Reset mid-operation: immediate return to IDLE, all outputs to reset values.

Test Plan:
- DIVU 100/7: stall from the accept cycle through WAIT; exactly one hilo_we_o pulse; lo_o=14, hi_o=2; stall_req_o=0 in the DONE cycle.
- DIV 0xFFFFFFF9/2 (−7/2): lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; div_signed_o=1 throughout WAIT.
- DIVU 5/0: lo_o=hi_o=0, single write pulse, no hang.
- Flush_i asserted 10 cycles into WAIT: div_discard_o=1 that cycle; start drops; no hilo_we_o; hi_o/lo_o keep prior values; a following DIVU 9/3 then yields lo=3, hi=0.
- Flush_i and div_ready_i in the same cycle: no write, return to IDLE. Separately, flush_i in the accept cycle: no issue, stall_req_o=0.
- Two back-to-back divides (20/6, then 21/4): two separate write pulses, each with correct HI/LO (2/3, then 1/5); no reissue of the first. Also assert rst=0 mid-WAIT: all outputs are 0 asynchronously.
